// File: rtl/snn_enc_pkg.sv
// Shared types and constants for the spike encoder: FSM states and lane LFSR definition.
package snn_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// One encoder lane random source: 16-bit Fibonacci LFSR with seed load and step enable.
module lfsr16
  import snn_enc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              en_i,
  output logic [LFSR_W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) q_o <= seed_i;
    else if (en_i)       q_o <= lfsr_next(q_o);
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: stored image is compared column-by-column against per-row LFSRs
// to build a shadow spike vector, which is handed to the neuron array on each step pulse.
//
// state | meaning
// IDLE  | waiting for start, pixel writes open
// BUILD | one column per cycle into shadow, COLS cycles
// READY | shadow complete, waiting for step_i to transfer
// DONE  | NUM_STEPS vectors delivered, pixel writes open
module spike_encoder
  import snn_enc_pkg::*;
#(
  parameter int              NUM_PIXEL = 961,
  parameter int              ROWS      = 31,
  parameter int              COLS      = 31,
  parameter int              PIX_WIDTH = 8,
  parameter int              NUM_STEPS = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pixel_we_i,
  input  logic [$clog2(NUM_PIXEL)-1:0] pixel_addr_i,
  input  logic [PIX_WIDTH-1:0]         pixel_data_i,
  input  logic                         start_i,
  input  logic                         step_i,
  output logic [NUM_PIXEL-1:0]         spike_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         underrun_o
);

  localparam int AW    = $clog2(NUM_PIXEL);
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW    = $clog2(NUM_STEPS + 1);
  localparam int CMP_W = (PIX_WIDTH > 8) ? PIX_WIDTH : 8;

  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(NUM_STEPS - 1);
  localparam logic [AW:0]   PIX_LIMIT = (AW + 1)'(NUM_PIXEL);

  enc_state_e state_q, state_d;

  logic [CW-1:0]        col_cnt_q;
  logic [SW-1:0]        step_cnt_q;
  logic [PIX_WIDTH-1:0] pix_mem [NUM_PIXEL];
  logic [NUM_PIXEL-1:0] shadow_q;
  logic [AW-1:0]        lane_idx [ROWS];
  logic [ROWS-1:0]      lane_hit;

  logic start_acc, build_en, xfer, spike_clr, underrun_set, pix_wr_open;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_acc    = 1'b0;
    build_en     = 1'b0;
    xfer         = 1'b0;
    spike_clr    = 1'b0;
    underrun_set = 1'b0;
    pix_wr_open  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pix_wr_open = 1'b1;
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = ST_BUILD;
        end
      end
      ST_BUILD: begin
        build_en = 1'b1;
        if (step_i) begin
          underrun_set = 1'b1;
          spike_clr    = 1'b1;
        end
        if (col_cnt_q == COL_LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (step_i) begin
          xfer    = 1'b1;
          state_d = (step_cnt_q == STEP_LAST) ? ST_DONE : ST_BUILD;
        end
      end
      ST_DONE: begin
        pix_wr_open = 1'b1;
        // start wins over a coincident step
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = ST_BUILD;
        end else if (step_i) begin
          spike_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_cnt_q  <= '0;
      step_cnt_q <= '0;
      underrun_o <= 1'b0;
      spike_o    <= '0;
    end else begin
      if (start_acc) begin
        col_cnt_q  <= '0;
        step_cnt_q <= '0;
        underrun_o <= 1'b0;
      end else begin
        if (build_en)     col_cnt_q  <= (col_cnt_q == COL_LAST) ? '0 : col_cnt_q + 1'b1;
        if (xfer)         step_cnt_q <= step_cnt_q + 1'b1;
        if (underrun_set) underrun_o <= 1'b1;
      end
      if (xfer)           spike_o <= shadow_q;
      else if (spike_clr) spike_o <= '0;
    end
  end

  // Pixel storage is deliberately outside reset so an image survives a sequencer restart.
  always_ff @(posedge clk_i) begin
    if (pixel_we_i && pix_wr_open && ({1'b0, pixel_addr_i} < PIX_LIMIT))
      pix_mem[pixel_addr_i] <= pixel_data_i;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-9:0] lfsr_unused;

    lfsr16 u_lfsr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (start_acc),
      .seed_i (LFSR_SEED + LFSR_W'(r)),
      .en_i   (build_en),
      .q_o    (lfsr_q)
    );

    // Only the low byte feeds the intensity compare.
    assign lfsr_unused = lfsr_q[LFSR_W-1:8];
    assign lane_idx[r] = AW'(r * COLS) + AW'(col_cnt_q);
    assign lane_hit[r] = CMP_W'(pix_mem[lane_idx[r]]) > CMP_W'(lfsr_q[7:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else if (build_en) begin
      for (int r = 0; r < ROWS; r++) shadow_q[lane_idx[r]] <= lane_hit[r];
    end
  end

  assign busy_o = (state_q == ST_BUILD) || (state_q == ST_READY);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: stimulus queues expected step responses, a monitor checks them.
module tb_spike_encoder;

  localparam int NP = 961;
  localparam int NR = 31;
  localparam int NC = 31;
  localparam int NS = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          pixel_we_i = 1'b0;
  logic [9:0]    pixel_addr_i = '0;
  logic [7:0]    pixel_data_i = '0;
  logic          start_i = 1'b0;
  logic          step_i = 1'b0;
  logic [NP-1:0] spike_o;
  logic          busy_o, done_o, underrun_o;

  always #5 clk_i = ~clk_i;

  spike_encoder #(
    .NUM_PIXEL(NP), .ROWS(NR), .COLS(NC), .PIX_WIDTH(8), .NUM_STEPS(NS), .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pixel_we_i(pixel_we_i), .pixel_addr_i(pixel_addr_i),
    .pixel_data_i(pixel_data_i), .start_i(start_i), .step_i(step_i), .spike_o(spike_o),
    .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o)
  );

  typedef struct {
    logic [NP-1:0] spike;
    int            pop;
    logic          underrun;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_pix [NP];
  logic [15:0] m_lfsr [NR];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every step_i the DUT samples produces a response to be checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      if (step_i && !rst_i) begin
        #1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: step seen with no expected entry");
        end else begin
          e = sb_q.pop_front();
          checkv("spike", spike_o, e.spike);
          check1("underrun", underrun_o, e.underrun);
          check1("busy", busy_o, e.busy);
          check1("done", done_o, e.done);
          checks++;
          if ($countones(spike_o) != e.pop) begin
            errors++;
            $display("FAIL popcount: got %0d expected %0d", $countones(spike_o), e.pop);
          end
        end
      end
    end
  end

  function automatic logic [15:0] adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_seed();
    for (int r = 0; r < NR; r++) m_lfsr[r] = SEED + 16'(r);
  endtask

  task automatic model_vec(output logic [NP-1:0] v, output int pop);
    v = '0;
    pop = 0;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (m_pix[r*NC+c] > m_lfsr[r][7:0]) begin
          v[10'(r*NC+c)] = 1'b1;
          pop++;
        end
      end
      for (int r = 0; r < NR; r++) m_lfsr[r] = adv(m_lfsr[r]);
    end
  endtask

  task automatic push_exp(input logic [NP-1:0] s, input int pop, input logic u, input logic b,
                          input logic d);
    exp_t e;
    e.spike = s; e.pop = pop; e.underrun = u; e.busy = b; e.done = d;
    sb_q.push_back(e);
  endtask

  task automatic pulse_step();
    step_i = 1'b1;
    @(negedge clk_i);
    step_i = 1'b0;
  endtask

  // Transfer in READY for step k, expectation from the reference model.
  task automatic step_ready(input int k, input logic u);
    logic [NP-1:0] v;
    int pop;
    model_vec(v, pop);
    push_exp(v, pop, u, (k != NS-1), (k == NS-1));
    pulse_step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // mode 0: all zero, 1: all 255, 2: pattern
  task automatic load_image(input int mode);
    for (int a = 0; a < NP; a++) begin
      logic [7:0] d;
      d = (mode == 0) ? 8'd0 : (mode == 1) ? 8'd255 : 8'((a*37 + 200) & 255);
      pixel_we_i = 1'b1;
      pixel_addr_i = 10'(a);
      pixel_data_i = d;
      m_pix[a] = d;
      @(negedge clk_i);
    end
    pixel_we_i = 1'b0;
  endtask

  task automatic start_enc();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    model_seed();
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_done", done_o, 1'b0);
    check1("rst_underrun", underrun_o, 1'b0);
    checkv("rst_spike", spike_o, '0);

    // All-zero image: every step delivers an empty vector.
    load_image(0);
    start_enc();
    for (int k = 0; k < 8; k++) begin
      repeat (31) @(negedge clk_i);
      push_exp('0, 0, 1'b0, 1'b1, 1'b0);
      pulse_step();
    end

    // All-255 image through the full step count, then a step in DONE.
    do_reset();
    load_image(1);
    start_enc();
    for (int k = 0; k < NS; k++) begin
      repeat (31) @(negedge clk_i);
      step_ready(k, 1'b0);
    end
    check1("done_after_last", done_o, 1'b1);
    push_exp('0, 0, 1'b0, 1'b0, 1'b1);
    pulse_step();

    // Writes in DONE are accepted; start with coincident step must win.
    load_image(2);
    push_exp('0, 0, 1'b0, 1'b1, 1'b0);
    step_i = 1'b1;
    start_enc();
    step_i = 1'b0;
    repeat (9) @(negedge clk_i);
    push_exp('0, 0, 1'b1, 1'b1, 1'b0);
    pulse_step();
    repeat (21) @(negedge clk_i);
    step_ready(0, 1'b1);

    // Reset at col 15 of step 3, then a restart must reproduce step 0.
    do_reset();
    check1("rst_clears_underrun", underrun_o, 1'b0);
    start_enc();
    for (int k = 0; k < 3; k++) begin
      repeat (31) @(negedge clk_i);
      step_ready(k, 1'b0);
    end
    repeat (15) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check1("midrst_busy", busy_o, 1'b0);
    checkv("midrst_spike", spike_o, '0);
    push_exp('0, 0, 1'b0, 1'b0, 1'b0);
    pulse_step();
    start_enc();
    repeat (31) @(negedge clk_i);
    step_ready(0, 1'b0);

    // Out-of-range and mid-BUILD writes must not disturb the image.
    do_reset();
    pixel_we_i = 1'b1;
    pixel_addr_i = 10'd961;
    pixel_data_i = 8'd0;
    @(negedge clk_i);
    pixel_we_i = 1'b0;
    start_enc();
    for (int a = 0; a < 16; a++) begin
      pixel_we_i = 1'b1;
      pixel_addr_i = 10'(a);
      pixel_data_i = 8'd0;
      @(negedge clk_i);
    end
    pixel_we_i = 1'b0;
    repeat (15) @(negedge clk_i);
    step_ready(0, 1'b0);
    repeat (31) @(negedge clk_i);
    step_ready(1, 1'b0);

    repeat (4) @(negedge clk_i);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter NUM_PIXEL, default 961, meaning pixels per image and width of spike_o (ROWS*COLS).
REQ-002 SHALL have parameter ROWS, default 31, meaning encoder lanes, one lane per image row.
REQ-003 SHALL have parameter COLS, default 31, meaning pixels per row and BUILD cycles per time step.
REQ-004 SHALL have parameter PIX_WIDTH, default 8, meaning pixel intensity width.
REQ-005 SHALL have parameter NUM_STEPS, default 16, meaning time steps per image.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning base seed; lane r seed = LFSR_SEED + r.
REQ-007 SHALL have port clk_i  in  1  meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i  in  1  meaning reset, synchronous, active-high.
REQ-009 SHALL have port pixel_we_i  in  1  meaning pixel write strobe.
REQ-010 SHALL have port pixel_addr_i  in  $clog2(NUM_PIXEL)  meaning pixel index, row-major (r*COLS+c).
REQ-011 SHALL have port pixel_data_i  in  PIX_WIDTH  meaning unsigned intensity.
REQ-012 SHALL have port start_i  in  1  meaning begin encoding of the stored image.
REQ-013 SHALL have port step_i  in  1  meaning time-step advance pulse, driven by the downstream neuron's next_stage.
REQ-014 SHALL have port spike_o  out  NUM_PIXEL  meaning spike vector for the current time step.
REQ-015 SHALL have port busy_o  out  1  meaning state is BUILD or READY.
REQ-016 SHALL have port done_o  out  1  meaning state is DONE.
REQ-017 SHALL have port underrun_o  out  1  meaning sticky flag: step_i arrived while BUILD.

Function
REQ-018 SHALL store pixels in a NUM_PIXEL x PIX_WIDTH register array; a write is accepted only when pixel_we_i=1, state is IDLE or DONE, and pixel_addr_i<NUM_PIXEL; all other writes are ignored.
REQ-019 SHALL implement FSM IDLE, BUILD, READY, DONE.
REQ-020 SHALL in IDLE or DONE, on start_i: go to BUILD, clear step_cnt and col_cnt, reload every lane LFSR with its seed; start_i is ignored in BUILD/READY.
REQ-021 SHALL in BUILD, each cycle, for every lane r with c=col_cnt: shadow[r*COLS+c] = (pixel[r*COLS+c] > lfsr_r[7:0]), unsigned compare; then advance every lane LFSR once.
REQ-022 SHALL use a 16-bit Fibonacci LFSR per lane, taps 16,14,13,11, shift left with feedback into bit 0.
REQ-023 SHALL increment col_cnt each BUILD cycle; when col_cnt==COLS-1, go to READY and wrap col_cnt to 0 (BUILD lasts exactly COLS cycles).
REQ-024 SHALL in READY, on step_i: copy shadow to spike_o on that edge, then increment step_cnt; go to DONE if the new step_cnt==NUM_STEPS, else to BUILD.
REQ-025 SHALL in BUILD, on step_i: set underrun_o, load spike_o with all zeros, keep building; step_cnt is not incremented.
REQ-026 SHALL in DONE, on step_i: clear spike_o to zero; remain in DONE.
REQ-027 SHALL ignore step_i in IDLE; spike_o holds its value.
REQ-028 SHALL give start_i priority over step_i when both are asserted in DONE.
REQ-029 SHALL clear underrun_o only by reset or by start_i accepted.
REQ-030 SHALL make a complete vector available with COLS+1 cycles from BUILD entry to the first possible transfer, so a 32-cycle step_i period never underruns.

Reset
REQ-031 SHALL on rst_i (any state, including mid-BUILD) force IDLE, spike_o=0, shadow=0, step_cnt=0, col_cnt=0, underrun_o=0, LFSRs to their seeds; busy_o=0, done_o=0.
REQ-032 SHALL leave pixel storage unchanged by reset.

Structure
REQ-033 SHALL place the FSM state enum, LFSR width (16), tap constants and the default seed in shared package snn_enc_pkg.
REQ-034 SHALL implement one lane LFSR as sub-module lfsr16 (ports clk_i, rst_i, load_i, seed_i, en_i, q_o), instantiated ROWS times.

Verification
REQ-035 SHALL cover: all pixels 0, start, eight step_i pulses every 32 cycles -> spike_o all zeros each step, underrun_o=0.
REQ-036 SHALL cover: all pixels 255, start, 32-cycle steps -> spike_o bit (r,c) equals reference-model LFSR compare; popcount equals model count per step.
REQ-037 SHALL cover: step_i 10 cycles after start -> underrun_o=1, spike_o=0; next step_i in READY loads a valid vector.
REQ-038 SHALL cover: NUM_STEPS=16 steps -> done_o rises after 16th transfer; 17th step_i clears spike_o; pixel write then accepted.
REQ-039 SHALL cover: rst_i at col_cnt=15 of step 3 -> IDLE, spike_o=0; restart reproduces step-0 vector bit-exact.
REQ-040 SHALL cover: pixel_we_i during BUILD, and pixel_addr_i=961 -> both writes ignored, encoded output unchanged.
